// File: rtl/selen_wb_timer.sv
// selen_wb_timer: Wishbone B4 pipelined timer/compare peripheral.
// Registers CTRL, PRESC, COUNT, COMPARE and STATUS. A prescaled tick
// advances COUNT, and a COUNT==COMPARE hit sets MATCH, which drives a
// level interrupt when IE is set. Every response is a single-cycle
// registered ack, or err for an unmapped offset. No wait states.
module selen_wb_timer #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int PS_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_stall_o,
  output logic            irq_o
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  // Merge write data into an old value, one byte lane per select bit.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        r[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        r[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return r;
  endfunction

  logic [2:0]      ctrl_q,  ctrl_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [PS_W-1:0] pcnt_q,  pcnt_d;
  logic [31:0]     count_q, count_d;
  logic [31:0]     cmp_q,   cmp_d;
  logic            match_q, match_d;
  logic            ack_q,   ack_d;
  logic            err_q,   err_d;
  logic [31:0]     dat_q,   dat_d;
  logic            irq_q,   irq_d;

  logic        acc_s, mapped_s, wr_s, tick_s, hit_s, w1c_s;
  logic [2:0]  off_s;
  logic [31:0] rdata_s, m_ctrl_s, m_presc_s, m_count_s, m_cmp_s;
  logic        unused_s;

  assign acc_s    = wb_cyc_i & wb_stb_i;
  assign off_s    = wb_adr_i[4:2];
  assign mapped_s = (off_s <= OFF_STATUS);
  assign wr_s     = acc_s & wb_we_i & mapped_s;
  assign tick_s   = ctrl_q[0] & (pcnt_q == presc_q);
  // The match test uses COUNT as it stands before any same-cycle bus write.
  assign hit_s    = tick_s & (count_q == cmp_q);
  assign w1c_s    = wr_s & (off_s == OFF_STATUS) & wb_sel_i[0] & wb_dat_i[0];

  assign m_ctrl_s  = apply_sel({29'd0, ctrl_q}, wb_dat_i, wb_sel_i);
  assign m_presc_s = apply_sel({{(32-PS_W){1'b0}}, presc_q}, wb_dat_i, wb_sel_i);
  assign m_count_s = apply_sel(count_q, wb_dat_i, wb_sel_i);
  assign m_cmp_s   = apply_sel(cmp_q, wb_dat_i, wb_sel_i);

  // Upper bits of the merged CTRL/PRESC words and the undecoded address bits
  // are intentionally dropped.
  assign unused_s = ^{m_ctrl_s[31:3], m_presc_s[31:PS_W],
                      wb_adr_i[AW-1:5], wb_adr_i[1:0]};

  // Read-data mux: register value as seen at the accept edge.
  always_comb begin
    rdata_s = 32'd0;
    case (off_s)
      OFF_CTRL:   rdata_s = {29'd0, ctrl_q};
      OFF_PRESC:  rdata_s = {{(32-PS_W){1'b0}}, presc_q};
      OFF_COUNT:  rdata_s = count_q;
      OFF_CMP:    rdata_s = cmp_q;
      OFF_STATUS: rdata_s = {31'd0, match_q};
      default:    rdata_s = 32'd0;
    endcase
  end

  // Next-state logic for registers, prescaler, counter and bus response.
  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    cmp_d   = cmp_q;

    if (wr_s && off_s == OFF_CTRL) begin
      ctrl_d = m_ctrl_s[2:0];
    end else begin
      ctrl_d = ctrl_q;
    end

    if (wr_s && off_s == OFF_PRESC) begin
      presc_d = m_presc_s[PS_W-1:0];
    end else begin
      presc_d = presc_q;
    end

    if (wr_s && off_s == OFF_CMP) begin
      cmp_d = m_cmp_s;
    end else begin
      cmp_d = cmp_q;
    end

    // A PRESC write restarts the prescale count; EN=0 freezes it.
    if (wr_s && off_s == OFF_PRESC) begin
      pcnt_d = '0;
    end else if (tick_s) begin
      pcnt_d = '0;
    end else if (ctrl_q[0]) begin
      pcnt_d = pcnt_q + {{(PS_W-1){1'b0}}, 1'b1};
    end else begin
      pcnt_d = pcnt_q;
    end

    // A bus write to COUNT overrides the tick update in the same cycle.
    if (wr_s && off_s == OFF_COUNT) begin
      count_d = m_count_s;
    end else if (hit_s && ctrl_q[1]) begin
      count_d = 32'd0;
    end else if (tick_s) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end

    // A new match beats a simultaneous write-1-to-clear.
    match_d = hit_s | (match_q & ~w1c_s);
    irq_d   = match_q & ctrl_q[2];

    ack_d = acc_s & mapped_s;
    err_d = acc_s & ~mapped_s;
    if (acc_s && !wb_we_i && mapped_s) begin
      dat_d = rdata_s;
    end else begin
      dat_d = 32'd0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= 3'd0;
      presc_q <= '0;
      pcnt_q  <= '0;
      count_q <= 32'd0;
      cmp_q   <= 32'd0;
      match_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
    end
  end

  // A response is discarded when the master drops its cycle.
  assign wb_ack_o   = ack_q & wb_cyc_i;
  assign wb_err_o   = err_q & wb_cyc_i;
  assign wb_dat_o   = dat_q;
  assign wb_stall_o = 1'b0;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_selen_wb_timer.sv
// Directed testbench for selen_wb_timer with hand-computed expectations.
module tb_selen_wb_timer;

  logic        clk;
  logic        rst_n;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_stall_o;
  logic        irq_o;

  int n_checks;
  int n_errors;

  selen_wb_timer #(.AW(32), .DW(32), .PS_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .wb_stall_o (wb_stall_o),
    .irq_o      (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = 32'd0;
    wb_dat_i = 32'd0;
    wb_sel_i = 4'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transfer: drive on negedge, accept on posedge, sample 1 ns later.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat,
                      output logic ack, output logic err);
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    @(posedge clk);
    #1;
    rdat = wb_dat_o;
    ack  = wb_ack_o;
    err  = wb_err_o;
    bus_idle();
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    logic a, e;
    xfer(1'b1, adr, dat, 4'hF, rd, a, e);
    chk("wr_ack", {31'd0, a}, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    logic a, e;
    xfer(1'b0, adr, 32'd0, 4'hF, rd, a, e);
    chk({tag, "_ack"}, {31'd0, a}, 32'd1);
    chk(tag, rd, exp);
  endtask

  logic        p_we  [4];
  logic [31:0] p_adr [4];
  logic [31:0] p_dat [4];
  logic [31:0] p_exp [4];

  initial begin
    logic [31:0] rd;
    logic a, e;
    int k;
    n_checks = 0;
    n_errors = 0;
    bus_idle();

    // Reset values
    do_reset();
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    rd_chk("rst_ctrl",   32'h00, 32'd0);
    rd_chk("rst_presc",  32'h04, 32'd0);
    rd_chk("rst_count",  32'h08, 32'd0);
    rd_chk("rst_cmp",    32'h0C, 32'd0);
    rd_chk("rst_status", 32'h10, 32'd0);

    // Pipelined back-to-back access
    p_we[0] = 1'b1; p_adr[0] = 32'h0C; p_dat[0] = 32'h10; p_exp[0] = 32'd0;
    p_we[1] = 1'b0; p_adr[1] = 32'h0C; p_dat[1] = 32'h0;  p_exp[1] = 32'h10;
    p_we[2] = 1'b1; p_adr[2] = 32'h00; p_dat[2] = 32'h1;  p_exp[2] = 32'd0;
    p_we[3] = 1'b0; p_adr[3] = 32'h00; p_dat[3] = 32'h0;  p_exp[3] = 32'h1;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_sel_i = 4'hF;
    wb_we_i = p_we[0]; wb_adr_i = p_adr[0]; wb_dat_i = p_dat[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("pipe_ack", {31'd0, wb_ack_o}, 32'd1);
      if (!p_we[i]) chk("pipe_rdata", wb_dat_o, p_exp[i]);
      if (i < 3) begin
        wb_we_i = p_we[i+1]; wb_adr_i = p_adr[i+1]; wb_dat_i = p_dat[i+1];
      end else begin
        bus_idle();
      end
    end

    // Count and match with auto reload
    do_reset();
    wr(32'h04, 32'd3);
    wr(32'h0C, 32'd2);
    wr(32'h00, 32'h7);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (irq_o) begin
        k = i;
        break;
      end
    end
    chk("irq_latency", k, 32'd13);
    rd_chk("match_status", 32'h10, 32'd1);
    rd_chk("reload_count", 32'h08, 32'd0);
    wr(32'h10, 32'd1);
    @(posedge clk);
    #1;
    chk("w1c_irq", {31'd0, irq_o}, 32'd0);

    // Wrap and COUNT-write collision
    do_reset();
    wr(32'h0C, 32'd5);
    wr(32'h08, 32'hFFFF_FFFF);
    wr(32'h00, 32'h1);
    rd_chk("wrap_pre",    32'h08, 32'hFFFF_FFFF);
    rd_chk("wrap_count",  32'h08, 32'd0);
    rd_chk("wrap_status", 32'h10, 32'd0);
    wr(32'h08, 32'h100);
    rd_chk("collide_count", 32'h08, 32'h100);

    // Byte lanes and unmapped offset
    do_reset();
    xfer(1'b1, 32'h0C, 32'hAABB_CCDD, 4'b0101, rd, a, e);
    chk("lane_wr_ack", {31'd0, a}, 32'd1);
    rd_chk("lane_cmp", 32'h0C, 32'h00BB_00DD);
    xfer(1'b0, 32'h18, 32'd0, 4'hF, rd, a, e);
    chk("unmap_err",  {31'd0, e}, 32'd1);
    chk("unmap_ack",  {31'd0, a}, 32'd0);
    chk("unmap_data", rd, 32'd0);

    // Cycle dropped in the response cycle
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h0C; wb_sel_i = 4'hF;
    @(posedge clk);
    #1;
    bus_idle();
    #1;
    chk("abort_ack", {31'd0, wb_ack_o}, 32'd0);

    // Reset asserted while running with an active interrupt
    do_reset();
    wr(32'h0C, 32'd0);
    wr(32'h00, 32'h5);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_irq", {31'd0, irq_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_irq", {31'd0, irq_o}, 32'd0);
    chk("mid_rst_ack", {31'd0, wb_ack_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_count", 32'h08, 32'd0);
    rd_chk("post_rst_ctrl",  32'h00, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
